// File: rtl/spi_cfg_pkg.sv
// Shared types and default constants for the serial configuration register file.
// Latency: n/a (package only).
// Backpressure: n/a; the serial master owns the pace of every frame.
package spi_cfg_pkg;

  // Frame receiver states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } spi_state_e;

  // Value of the R/W header bit that marks a read frame.
  localparam logic SPI_RW_READ = 1'b1;

  // Default geometry.
  localparam int SPI_ADDR_W_DEF   = 7;
  localparam int SPI_DATA_W_DEF   = 8;
  localparam int SPI_NUM_REGS_DEF = 4;

  // Total bits in a complete frame: R/W bit, address field, data field.
  function automatic int spi_frame_bits(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// Serial frame receiver: framing FSM, bit counter and input shift register.
// Latency: commit/hdr_done are combinational for the edge that captures the last data/header bit.
// Backpressure: none; bits are accepted on every sclk rising edge while cs_n is low.
//
// Ports:
//   sclk, rstn      clock and async active-low reset
//   cs_n, serial_in frame select (active low) and serial data, MSB first
//   rw, addr, data  decoded frame fields, valid while commit or hdr_done is high
//   commit          high in the cycle whose rising edge captures the last data bit
//   hdr_done        high in the cycle whose rising edge captures the last header bit
//   data_phase      high in cycles whose rising edge captures a data bit
//   bit_cnt         bits received in the current frame, saturating at a full frame
module spi_frame_rx
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W_DEF,
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int CNT_W  = $clog2(ADDR_W + DATA_W + 2)
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              cs_n,
  input  logic              serial_in,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              commit,
  output logic              hdr_done,
  output logic              data_phase,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int FRAME_W = spi_frame_bits(ADDR_W, DATA_W);

  // Count values seen just before the edge that captures the last header
  // bit, the last data bit, respectively.
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  spi_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // One bit shorter than a frame: the final bit is taken straight from
  // serial_in when the frame completes, so it never needs storing.
  logic [FRAME_W-2:0]       shift_q, shift_d;
  logic [FRAME_W-1:0]       shift_nxt;
  logic [ADDR_W:0]          hdr_bits;

  assign shift_nxt = {shift_q, serial_in};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    hdr_done = 1'b0;
    commit   = 1'b0;
    if (cs_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (state_q != DONE) begin
      shift_d = shift_nxt[FRAME_W-2:0];
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == HDR_LAST) begin
        hdr_done = 1'b1;
        state_d  = DATA;
      end else if (cnt_q == FRAME_LAST) begin
        commit  = 1'b1;
        state_d = DONE;
      end else if (state_q == IDLE) begin
        state_d = HEADER;
      end
    end
  end

  // At hdr_done the header sits in the low bits of the incoming word; at
  // commit it sits above the data field.
  always_comb begin
    hdr_bits = shift_nxt[FRAME_W-1:DATA_W];
    if (hdr_done) begin
      hdr_bits = shift_nxt[ADDR_W:0];
    end
  end

  assign rw         = hdr_bits[ADDR_W];
  assign addr       = hdr_bits[ADDR_W-1:0];
  assign data       = shift_nxt[DATA_W-1:0];
  assign data_phase = !cs_n && (state_q == DATA);
  assign bit_cnt    = cnt_q;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/spi_cfg_regfile.sv
// Serial-loaded configuration register file with write strobe and optional readback.
// Latency: a write lands on regs_out at the edge capturing the last data bit; wr_stb follows for one cycle.
// Backpressure: none; the serial master paces frames, and out-of-range/aborted/read frames are dropped.
//
// Ports:
//   sclk, rstn   clock and async active-low reset
//   cs_n         frame select, active low
//   serial_in    serial data, MSB first: R/W bit, address, data
//   serial_out   readback data during a read frame's data phase, otherwise 0
//   regs_out     flat register image, register k at [k*DATA_W +: DATA_W]
//   wr_stb       one-cycle pulse after a committed write
//   wr_addr      address of the last committed write
//   bit_cnt      bits received in the current frame
//
// Build option: define SPI_CFG_READBACK_EN to enable serial readback;
// without it serial_out is tied low and read frames are discarded.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W   = SPI_ADDR_W_DEF,
  parameter int DATA_W   = SPI_DATA_W_DEF,
  parameter int NUM_REGS = SPI_NUM_REGS_DEF,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                               sclk,
  input  logic                               rstn,
  input  logic                               cs_n,
  input  logic                               serial_in,
  output logic                               serial_out,
  output logic [NUM_REGS*DATA_W-1:0]         regs_out,
  output logic                               wr_stb,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic [$clog2(ADDR_W+DATA_W+2)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 2);
  localparam logic [ADDR_W:0] NUM_REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

  logic              rx_rw;
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_commit;
  logic              rx_hdr_done;
  logic              rx_data_phase;
  logic              addr_in_range;
  logic              wr_ok;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  spi_frame_rx #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rx (
    .sclk       (sclk),
    .rstn       (rstn),
    .cs_n       (cs_n),
    .serial_in  (serial_in),
    .rw         (rx_rw),
    .addr       (rx_addr),
    .data       (rx_data),
    .commit     (rx_commit),
    .hdr_done   (rx_hdr_done),
    .data_phase (rx_data_phase),
    .bit_cnt    (bit_cnt)
  );

  // Zero-extend so the compare is safe even when NUM_REGS == 2**ADDR_W.
  assign addr_in_range = ({1'b0, rx_addr} < NUM_REGS_LIM);
  assign wr_ok         = rx_commit && (rx_rw != SPI_RW_READ) && addr_in_range;

  always_comb begin
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    if (wr_ok) begin
      wr_stb_d  = 1'b1;
      wr_addr_d = rx_addr;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_ok && (rx_addr == ADDR_W'(k))) begin
        regs_d[k] = rx_data;
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RST_VAL[k*DATA_W +: DATA_W];
      end
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;

`ifdef SPI_CFG_READBACK_EN
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d;

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rx_addr == ADDR_W'(k)) begin
        rd_word = regs_q[k];
      end
    end
  end

  // Loaded at the last header edge so the MSB is ready for the first data
  // edge; every data edge then advances one bit, back-filling zeros so the
  // line is low once the last data bit has gone out.
  always_comb begin
    rd_shift_d = rd_shift_q;
    if (cs_n) begin
      rd_shift_d = '0;
    end else if (rx_hdr_done) begin
      rd_shift_d = (rx_rw == SPI_RW_READ) ? rd_word : '0;
    end else if (rx_data_phase) begin
      rd_shift_d = rd_shift_q << 1;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rd_shift_q <= '0;
    end else begin
      rd_shift_q <= rd_shift_d;
    end
  end

  assign serial_out = rd_shift_q[DATA_W-1];
`else
  logic unused_rd;
  assign unused_rd  = ^{rx_hdr_done, rx_data_phase};
  assign serial_out = 1'b0;
`endif

endmodule

// File: doc/spi_cfg_regfile.md
# spi_cfg_regfile

Parametrised serial configuration register file. It is the next generation of the fixed three-register SPI loader. Frames on `serial_in` carry a read/write bit, an address and a data word. Writes go to a generic array of `NUM_REGS` registers, each `DATA_W` bits wide, and all registers are exposed as a flat bus to the chip core. Adds framing via `cs_n`, a write strobe, out-of-range protection and optional serial readback.

## Interface
Parameters:
- `ADDR_W`, 7, address field width; header is `ADDR_W+1` bits.
- `DATA_W`, 8, register and data field width.
- `NUM_REGS`, 4, number of implemented registers (addresses 0..NUM_REGS-1); must be at most 2**ADDR_W.
- `RST_VAL`, '0, flat `NUM_REGS*DATA_W` reset image; register k occupies slice [k*DATA_W +: DATA_W].

Ports (one clock, `sclk`; reset `rstn` is asynchronous, active-low):
- `sclk`  in  1  serial clock; all state changes on the rising edge.
- `rstn`  in  1  async active-low reset.
- `cs_n`  in  1  frame select, active-low, sampled synchronously on `sclk`.
- `serial_in`  in  1  serial data, MSB first.
- `serial_out`  out  1  readback data.
- `regs_out`  out  NUM_REGS*DATA_W  flat register contents.
- `wr_stb`  out  1  one-cycle pulse on a committed write.
- `wr_addr`  out  ADDR_W  address of the last committed write.
- `bit_cnt`  out  $clog2(ADDR_W+DATA_W+2)  bits received in the current frame; successor of `load_cnt_ser`.

## Operation
- Frame: header bit 0 is R/W (1 = read), followed by `ADDR_W` address bits, then `DATA_W` data bits. Every field is MSB first.
- FSM states are IDLE, HEADER, DATA and DONE.
  - IDLE: entered whenever `cs_n`=1 at a rising edge, from any state. Clears `bit_cnt` and the shift register.
  - IDLE to HEADER: first edge with `cs_n`=0. The bit on `serial_in` is captured at that edge.
  - HEADER to DATA: after `ADDR_W+1` bits.
  - DATA to DONE: after `DATA_W` more bits.
  - DONE: ignores further bits. `bit_cnt` saturates at `ADDR_W+DATA_W+1`. Leaves only via `cs_n`=1.
- Write commit happens at the edge capturing the last data bit, and only if R/W=0 and address < `NUM_REGS`:
  - the register is updated;
  - `wr_stb`=1 for exactly the following cycle;
  - `wr_addr` is updated.
- Out-of-range address: no register change, no `wr_stb`.
- Aborted frame (`cs_n` rises before the last data bit): no write, no `wr_stb`.
- Read frames never modify registers and never pulse `wr_stb`.
- Reset mid-frame: every output returns immediately to its reset value; the partial frame is discarded.

## Timing
- Reset values:
  - `regs_out`=`RST_VAL`
  - `serial_out`=0
  - `wr_stb`=0
  - `wr_addr`=0
  - `bit_cnt`=0
  - state IDLE
- Write latency: the new value appears on `regs_out` after the rising edge of frame bit `ADDR_W+DATA_W+1` (the 16th edge at defaults).
- `wr_stb` is high from that edge to the next edge.
- Readback timing: `serial_out` is updated on rising edges.
  - Data MSB is valid after the edge capturing the last header bit.
  - The master samples it on the next rising edge.
  - Each following data bit is valid one edge later.
  - `serial_out` is 0 outside a read data phase.
- `bit_cnt` increments on each edge with `cs_n`=0 until saturation.

## Configuration
- `SPI_CFG_READBACK_EN`, defined:
  - A read frame to address < `NUM_REGS` shifts that register out on `serial_out` during the data phase.
  - A read of an out-of-range address shifts out zeros.
- Not defined:
  - `serial_out` is constant 0.
  - Read frames are parsed and counted, then discarded.
  - No readback shift register is synthesised.

## Structure
- Shared package `spi_cfg_pkg` holds:
  - state enum `spi_state_e` {IDLE, HEADER, DATA, DONE};
  - localparam `SPI_RW_READ`=1'b1;
  - the default width constants.
- One sub-module, `spi_frame_rx`:
  - contains the FSM, the bit counter and the input shift register;
  - outputs the decoded `rw`, `addr`, `data`, a `commit` pulse and a `hdr_done` pulse.
- `spi_cfg_regfile` contains the register array, the address decode and the readback shifter.

## Test plan
All scenarios use defaults (ADDR_W=7, DATA_W=8, NUM_REGS=4, RST_VAL=0).
1. Pulse `rstn` low → `regs_out`=0, `serial_out`=0, `bit_cnt`=0, `wr_stb`=0.
2. `cs_n`=0; shift header 0x02, then 0xAB → after the 16th edge reg2=0xAB, `wr_stb` high for one cycle, `wr_addr`=2; other registers remain 0.
3. Header 0x01, then 5 data bits, then `cs_n`=1 → reg1 unchanged, no `wr_stb`; the next full frame (header 0x01, data 0x3C) writes 0x3C.
4. Header 0x05 (out of range) with data 0xFF, followed by 4 extra bits → no register change, no `wr_stb`, `bit_cnt` saturates at 16.
5. With `SPI_CFG_READBACK_EN`: write reg3=0x5A, then read header 0x83 → `serial_out` = 0,1,0,1,1,0,1,0 on data edges 1–8; reg3 stays 0x5A and `wr_stb` stays 0. Without the macro, `serial_out` stays 0.
6. Assert `rstn` low after 10 bits of a write frame to reg0 with data 0xFF → reg0=0, `bit_cnt`=0; after release, a fresh frame writes normally.
